// File: rtl/memoria_datos_bytes.sv
// memoria_datos_bytes
//   Byte-addressable data memory for the MIPS pipeline MEM stage. It handles
//   byte, halfword and word loads and stores, sign or zero extends loads, and
//   flags misaligned or illegal accesses. After reset, a sequencer writes an
//   initial value into every word. Pipeline accesses are ignored until that
//   sequence finishes. A separate debug port reads one word per cycle.
//
// Ports
//   i_clk              clock, rising edge
//   i_reset            asynchronous, active-high reset
//   i_ALUDireccion     byte address of the pipeline access
//   i_DatoRegistro     store data (sb uses [7:0], sh uses [15:0])
//   i_MemWrite         store request
//   i_MemRead          load request
//   i_Tamanio          access size: 00 byte, 01 half, 10 word, 11 illegal
//   i_ConSigno         loads: 1 sign-extend, 0 zero-extend
//   i_DebugDireccion   debug word index (taken modulo CELDAS)
//   o_DatoLeido        registered load data
//   o_DebugDato        registered debug word
//   o_Listo            high once initialisation has completed
//   o_ErrorAlineacion  one-cycle pulse after a misaligned/illegal access
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | writing the init value into word cnt, one word per cycle
// READY | serving pipeline loads/stores
module memoria_datos_bytes #(
  parameter int NBITS       = 32,
  parameter int CELDAS      = 16,
  parameter int INIT_INDICE = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NBITS-1:0] i_ALUDireccion,
  input  logic [NBITS-1:0] i_DatoRegistro,
  input  logic             i_MemWrite,
  input  logic             i_MemRead,
  input  logic [1:0]       i_Tamanio,
  input  logic             i_ConSigno,
  input  logic [NBITS-1:0] i_DebugDireccion,
  output logic [NBITS-1:0] o_DatoLeido,
  output logic [NBITS-1:0] o_DebugDato,
  output logic             o_Listo,
  output logic             o_ErrorAlineacion
);

  localparam int AW = $clog2(CELDAS);
  localparam int NB = NBITS / 8;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [1:0] TAM_BYTE = 2'b00;
  localparam logic [1:0] TAM_HALF = 2'b01;
  localparam logic [1:0] TAM_WORD = 2'b10;

  logic [0:0]       estado_q, estado_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] dato_leido_q, dato_leido_d;
  logic [NBITS-1:0] debug_dato_q, debug_dato_d;
  logic             error_q, error_d;

  logic [NBITS-1:0] mem_q [CELDAS];

  logic [AW-1:0]    idx_acc;
  logic [AW-1:0]    idx_dbg;
  logic [1:0]       carril;
  logic             desalineado;
  logic             acceso;
  logic [NBITS-1:0] palabra_rd;
  logic [NBITS-1:0] palabra_dbg;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [NBITS-1:0] valor_carga;
  logic [NBITS-1:0] valor_init;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [NBITS-1:0] mem_wdata;
  logic [NB-1:0]    mem_be;

  // Upper address bits are ignored, so addresses wrap modulo 4*CELDAS.
  logic unused_dir;
  assign unused_dir = ^{i_ALUDireccion[NBITS-1:AW+2], i_DebugDireccion[NBITS-1:AW]};

  assign idx_acc = i_ALUDireccion[AW+1:2];
  assign carril  = i_ALUDireccion[1:0];
  assign idx_dbg = i_DebugDireccion[AW-1:0];
  assign acceso  = i_MemRead | i_MemWrite;

  // Half needs addr[0]=0. Word needs addr[1:0]=00. Size 11 is never legal.
  always_comb begin
    desalineado = 1'b0;
    case (i_Tamanio)
      TAM_BYTE: desalineado = 1'b0;
      TAM_HALF: desalineado = carril[0];
      TAM_WORD: desalineado = (carril != 2'b00);
      default:  desalineado = 1'b1;
    endcase
  end

  // Both reads use the contents from before this edge's write, which gives
  // read-first behaviour for a load and a store to the same word.
  assign palabra_rd  = mem_q[idx_acc];
  assign palabra_dbg = mem_q[idx_dbg];

  always_comb begin
    byte_sel    = palabra_rd[8*carril +: 8];
    half_sel    = carril[1] ? palabra_rd[16 +: 16] : palabra_rd[0 +: 16];
    valor_carga = palabra_rd;
    case (i_Tamanio)
      TAM_BYTE: valor_carga = {{(NBITS-8){i_ConSigno & byte_sel[7]}}, byte_sel};
      TAM_HALF: valor_carga = {{(NBITS-16){i_ConSigno & half_sel[15]}}, half_sel};
      default:  valor_carga = palabra_rd;
    endcase
  end

  always_comb begin
    valor_init = '0;
    if (INIT_INDICE != 0) valor_init[AW-1:0] = cnt_q;
  end

  // A single write port is shared between the init sequencer and pipeline stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx_acc;
    mem_wdata = i_DatoRegistro;
    mem_be    = '0;
    if (estado_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = valor_init;
      mem_be    = '1;
    end else if (i_MemWrite && !desalineado) begin
      mem_we = 1'b1;
      case (i_Tamanio)
        TAM_BYTE: begin
          mem_wdata = {NB{i_DatoRegistro[7:0]}};
          mem_be    = NB'(1) << carril;
        end
        TAM_HALF: begin
          mem_wdata = {(NB/2){i_DatoRegistro[15:0]}};
          mem_be    = carril[1] ? NB'(4'b1100) : NB'(4'b0011);
        end
        default: begin
          mem_wdata = i_DatoRegistro;
          mem_be    = '1;
        end
      endcase
    end
  end

  always_comb begin
    estado_d     = estado_q;
    cnt_d        = cnt_q;
    dato_leido_d = dato_leido_q;
    debug_dato_d = palabra_dbg;
    error_d      = 1'b0;
    case (estado_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(CELDAS - 1)) estado_d = ST_READY;
      end
      ST_READY: begin
        error_d = acceso & desalineado;
        if (i_MemRead && !desalineado) dato_leido_d = valor_carga;
      end
      default: estado_d = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      estado_q     <= ST_INIT;
      cnt_q        <= '0;
      dato_leido_q <= '0;
      debug_dato_q <= '0;
      error_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      cnt_q        <= cnt_d;
      dato_leido_q <= dato_leido_d;
      debug_dato_q <= debug_dato_d;
      error_q      <= error_d;
    end
  end

  // The storage array has no reset because INIT rewrites every word. If
  // reset is high at a clock edge, the write is dropped.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_reset) begin
      for (int k = 0; k < NB; k++) begin
        if (mem_be[k]) mem_q[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  assign o_DatoLeido       = dato_leido_q;
  assign o_DebugDato       = debug_dato_q;
  assign o_Listo           = (estado_q == ST_READY);
  assign o_ErrorAlineacion = error_q;

endmodule

// File: tb/tb_memoria_datos_bytes.sv
module tb_memoria_datos_bytes;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_ALUDireccion = '0;
  logic [31:0] i_DatoRegistro = '0;
  logic        i_MemWrite = 1'b0;
  logic        i_MemRead = 1'b0;
  logic [1:0]  i_Tamanio = 2'b10;
  logic        i_ConSigno = 1'b0;
  logic [31:0] i_DebugDireccion = '0;
  logic [31:0] o_DatoLeido;
  logic [31:0] o_DebugDato;
  logic        o_Listo;
  logic        o_ErrorAlineacion;

  int tests_run = 0;
  int fails = 0;

  // Reference model: a flat array of 64 bytes (16 words x 4), little-endian.
  logic [7:0]  mb [64];
  logic [31:0] exp_dato;
  logic [31:0] exp_dbg;
  logic        exp_err;

  always #5 clk = ~clk;

  memoria_datos_bytes #(.NBITS(32), .CELDAS(16), .INIT_INDICE(1)) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_ALUDireccion(i_ALUDireccion),
    .i_DatoRegistro(i_DatoRegistro),
    .i_MemWrite(i_MemWrite),
    .i_MemRead(i_MemRead),
    .i_Tamanio(i_Tamanio),
    .i_ConSigno(i_ConSigno),
    .i_DebugDireccion(i_DebugDireccion),
    .o_DatoLeido(o_DatoLeido),
    .o_DebugDato(o_DebugDato),
    .o_Listo(o_Listo),
    .o_ErrorAlineacion(o_ErrorAlineacion)
  );

  task automatic model_init();
    for (int w = 0; w < 16; w++) begin
      mb[4*w]   = 8'(w);
      mb[4*w+1] = 8'h00;
      mb[4*w+2] = 8'h00;
      mb[4*w+3] = 8'h00;
    end
    exp_dato = '0;
    exp_dbg  = '0;
    exp_err  = 1'b0;
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  // Drives one READY-state cycle. Updates the model from the access rules,
  // then advances to just after the sampling edge.
  task automatic acc(input bit we, input bit re, input logic [1:0] tam, input bit sg,
                     input logic [31:0] addr, input logic [31:0] data, input logic [31:0] dbg);
    int n;
    int a;
    bit mis;
    logic [31:0] v;
    i_MemWrite       = we;
    i_MemRead        = re;
    i_Tamanio        = tam;
    i_ConSigno       = sg;
    i_ALUDireccion   = addr;
    i_DatoRegistro   = data;
    i_DebugDireccion = dbg;
    n   = (tam == 2'b00) ? 1 : (tam == 2'b01) ? 2 : 4;
    a   = int'(addr[5:0]);
    mis = (tam == 2'b11) || ((a % n) != 0);
    exp_dbg = model_word(int'(dbg[3:0]));
    exp_err = (we || re) && mis;
    if (re && !mis) begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[a+i]) << (8*i));
      if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      exp_dato = v;
    end
    if (we && !mis) begin
      for (int i = 0; i < n; i++) mb[a+i] = 8'(data >> (8*i));
    end
    @(posedge clk);
    #1;
    i_MemWrite = 1'b0;
    i_MemRead  = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    #2;
    tests_run++;
    if (o_DatoLeido !== 32'h0) begin fails++; $display("FAIL reset_dato got %h want 00000000", o_DatoLeido); end
    tests_run++;
    if (o_DebugDato !== 32'h0) begin fails++; $display("FAIL reset_debug got %h want 00000000", o_DebugDato); end
    tests_run++;
    if (o_Listo !== 1'b0) begin fails++; $display("FAIL reset_listo got %b want 0", o_Listo); end
    tests_run++;
    if (o_ErrorAlineacion !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", o_ErrorAlineacion); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Pipeline requests held throughout INIT must have no effect.
    i_MemRead = 1'b1; i_MemWrite = 1'b1; i_Tamanio = 2'b10;
    i_ALUDireccion = 32'h0; i_DatoRegistro = 32'hFFFF_FFFF; i_DebugDireccion = 32'h0;
    i_reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      tests_run++;
      if (o_Listo !== (e == 16)) begin fails++; $display("FAIL init_listo edge %0d got %b want %b", e, o_Listo, (e == 16)); end
      tests_run++;
      if (o_ErrorAlineacion !== 1'b0) begin fails++; $display("FAIL init_error edge %0d got %b want 0", e, o_ErrorAlineacion); end
    end
    i_MemRead = 1'b0; i_MemWrite = 1'b0;
    tests_run++;
    if (o_DatoLeido !== 32'h0) begin fails++; $display("FAIL init_load_ignored got %h want 00000000", o_DatoLeido); end
    model_init();
    acc(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'd0);
    tests_run++;
    if (o_DebugDato !== 32'h0) begin fails++; $display("FAIL init_store_ignored got %h want 00000000", o_DebugDato); end
  endtask

  task automatic test_debug();
    acc(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'd5);
    tests_run++;
    if (o_DebugDato !== 32'h5) begin fails++; $display("FAIL debug_idx5 got %h want 00000005", o_DebugDato); end
    acc(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'd21);
    tests_run++;
    if (o_DebugDato !== 32'h5) begin fails++; $display("FAIL debug_wrap21 got %h want 00000005", o_DebugDato); end
  endtask

  task automatic test_subword_loads();
    logic [31:0] la [5] = '{32'h09, 32'h0A, 32'h0A, 32'h0A, 32'h08};
    logic [1:0]  lt [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    bit          ls [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] le [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01};
    acc(1, 0, 2'b10, 0, 32'h08, 32'h80FF_7F01, 32'd2);
    for (int i = 0; i < 5; i++) begin
      acc(0, 1, lt[i], ls[i], la[i], 32'h0, 32'd2);
      tests_run++;
      if (o_DatoLeido !== le[i]) begin fails++; $display("FAIL subword_load_%0d got %h want %h", i, o_DatoLeido, le[i]); end
    end
    tests_run++;
    if (o_DebugDato !== 32'h80FF_7F01) begin fails++; $display("FAIL subword_debug got %h want 80ff7f01", o_DebugDato); end
  endtask

  task automatic test_byte_store();
    acc(1, 0, 2'b00, 0, 32'h0D, 32'h0000_00AB, 32'd3);
    acc(0, 0, 2'b00, 0, 32'h00, 32'h0, 32'd3);
    tests_run++;
    if (o_DebugDato !== 32'h0000_AB03) begin fails++; $display("FAIL sb_lane1 got %h want 0000ab03", o_DebugDato); end
    acc(1, 0, 2'b01, 0, 32'h0E, 32'h0000_1234, 32'd3);
    acc(0, 0, 2'b00, 0, 32'h00, 32'h0, 32'd3);
    tests_run++;
    if (o_DebugDato !== 32'h1234_AB03) begin fails++; $display("FAIL sh_upper got %h want 1234ab03", o_DebugDato); end
  endtask

  task automatic test_misalign();
    acc(0, 1, 2'b10, 0, 32'h10, 32'h0, 32'd0);
    tests_run++;
    if (o_DatoLeido !== 32'h4) begin fails++; $display("FAIL lw_aligned got %h want 00000004", o_DatoLeido); end
    acc(0, 1, 2'b10, 0, 32'h06, 32'h0, 32'd0);
    tests_run++;
    if (o_ErrorAlineacion !== 1'b1) begin fails++; $display("FAIL lw_mis_err got %b want 1", o_ErrorAlineacion); end
    tests_run++;
    if (o_DatoLeido !== 32'h4) begin fails++; $display("FAIL lw_mis_hold got %h want 00000004", o_DatoLeido); end
    acc(0, 0, 2'b10, 0, 32'h00, 32'h0, 32'd0);
    tests_run++;
    if (o_ErrorAlineacion !== 1'b0) begin fails++; $display("FAIL err_one_cycle got %b want 0", o_ErrorAlineacion); end
    acc(1, 0, 2'b01, 0, 32'h03, 32'h0000_FFFF, 32'd0);
    tests_run++;
    if (o_ErrorAlineacion !== 1'b1) begin fails++; $display("FAIL sh_mis_err got %b want 1", o_ErrorAlineacion); end
    acc(0, 0, 2'b10, 0, 32'h00, 32'h0, 32'd0);
    tests_run++;
    if (o_DebugDato !== 32'h0) begin fails++; $display("FAIL sh_mis_nowrite got %h want 00000000", o_DebugDato); end
    acc(0, 1, 2'b11, 0, 32'h00, 32'h0, 32'd0);
    tests_run++;
    if (o_ErrorAlineacion !== 1'b1) begin fails++; $display("FAIL tam11_err got %b want 1", o_ErrorAlineacion); end
    acc(1, 0, 2'b11, 0, 32'h00, 32'h5555_5555, 32'd0);
    tests_run++;
    if (o_ErrorAlineacion !== 1'b1) begin fails++; $display("FAIL back_to_back_err got %b want 1", o_ErrorAlineacion); end
    acc(0, 0, 2'b10, 0, 32'h00, 32'h0, 32'd0);
    tests_run++;
    if (o_ErrorAlineacion !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", o_ErrorAlineacion); end
    tests_run++;
    if (o_DebugDato !== 32'h0) begin fails++; $display("FAIL tam11_nowrite got %h want 00000000", o_DebugDato); end
  endtask

  task automatic test_read_first();
    acc(1, 1, 2'b10, 0, 32'h04, 32'hDEAD_BEEF, 32'd1);
    tests_run++;
    if (o_DatoLeido !== 32'h1) begin fails++; $display("FAIL rf_load_old got %h want 00000001", o_DatoLeido); end
    tests_run++;
    if (o_DebugDato !== 32'h1) begin fails++; $display("FAIL rf_debug_old got %h want 00000001", o_DebugDato); end
    acc(0, 1, 2'b10, 0, 32'h04, 32'h0, 32'd1);
    tests_run++;
    if (o_DatoLeido !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rf_load_new got %h want deadbeef", o_DatoLeido); end
    acc(0, 1, 2'b10, 0, 32'h44, 32'h0, 32'd1);
    tests_run++;
    if (o_DatoLeido !== 32'hDEAD_BEEF) begin fails++; $display("FAIL addr_wrap_44 got %h want deadbeef", o_DatoLeido); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [1:0]  tam;
    for (int it = 0; it < 400; it++) begin
      tam  = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (tam == 2'b01) addr[0] = 1'b0;
        if (tam == 2'b10) addr[1:0] = 2'b00;
      end
      acc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tam, 1'($urandom_range(0, 1)),
          addr, $urandom, $urandom);
      tests_run++;
      if (o_DatoLeido !== exp_dato) begin fails++; $display("FAIL rnd_dato it %0d got %h want %h", it, o_DatoLeido, exp_dato); end
      tests_run++;
      if (o_ErrorAlineacion !== exp_err) begin fails++; $display("FAIL rnd_err it %0d got %b want %b", it, o_ErrorAlineacion, exp_err); end
      tests_run++;
      if (o_DebugDato !== exp_dbg) begin fails++; $display("FAIL rnd_debug it %0d got %h want %h", it, o_DebugDato, exp_dbg); end
    end
  endtask

  task automatic test_reset_mid_init();
    acc(1, 0, 2'b10, 0, 32'h08, 32'hCAFE_F00D, 32'd2);
    acc(0, 1, 2'b10, 0, 32'h08, 32'h0, 32'd2);
    tests_run++;
    if (o_DatoLeido !== 32'hCAFE_F00D) begin fails++; $display("FAIL pre_reset_load got %h want cafef00d", o_DatoLeido); end
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      tests_run++;
      if (o_Listo !== 1'b0) begin fails++; $display("FAIL partial_init_listo edge %0d got %b want 0", e, o_Listo); end
    end
    i_reset = 1'b1;
    #1;
    tests_run++;
    if (o_Listo !== 1'b0) begin fails++; $display("FAIL mid_init_reset_listo got %b want 0", o_Listo); end
    @(posedge clk); #1;
    i_MemRead = 1'b1; i_Tamanio = 2'b10; i_ALUDireccion = 32'h08;
    i_reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      tests_run++;
      if (o_Listo !== (e == 16)) begin fails++; $display("FAIL reinit_listo edge %0d got %b want %b", e, o_Listo, (e == 16)); end
    end
    i_MemRead = 1'b0;
    tests_run++;
    if (o_DatoLeido !== 32'h0) begin fails++; $display("FAIL reinit_load_ignored got %h want 00000000", o_DatoLeido); end
    model_init();
    acc(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'd2);
    tests_run++;
    if (o_DebugDato !== 32'h2) begin fails++; $display("FAIL reinit_word2 got %h want 00000002", o_DebugDato); end
    acc(0, 1, 2'b10, 0, 32'h04, 32'h0, 32'd15);
    tests_run++;
    if (o_DatoLeido !== 32'h1) begin fails++; $display("FAIL reinit_word1 got %h want 00000001", o_DatoLeido); end
    tests_run++;
    if (o_DebugDato !== 32'hF) begin fails++; $display("FAIL reinit_word15 got %h want 0000000f", o_DebugDato); end
  endtask

  initial begin
    #1;
    test_reset();
    test_debug();
    test_subword_loads();
    test_byte_store();
    test_misalign();
    test_read_first();
    test_random();
    test_reset_mid_init();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
